// File: rtl/cpu_wr_flags_poller.sv
// Avalon-MM master that polls an 8-bit flags PIO on a programmable interval,
// debounces the samples, latches per-bit change flags and raises a level irq.
module cpu_wr_flags_poller #(
    parameter int WIDTH          = 8,
    parameter int CNT_W          = 16,
    parameter int PERIOD_DEFAULT = 1000,
    parameter int READ_LATENCY   = 1,
    parameter int STABLE_COUNT   = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic [1:0]       m_address,
    output logic             m_read,
    input  logic [31:0]      m_readdata,
    input  logic [1:0]       s_address,
    input  logic             s_read,
    input  logic             s_write,
    input  logic [31:0]      s_writedata,
    output logic [31:0]      s_readdata,
    output logic [WIDTH-1:0] flags,
    output logic             flags_valid,
    output logic             irq
);

    localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam int STB_W = $clog2(STABLE_COUNT + 1);
    localparam logic [STB_W-1:0] STB_MAX = STB_W'(STABLE_COUNT);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        READ,
        LAT,
        EVAL
    } state_t;

    state_t             state_q,       state_d;
    logic [CNT_W-1:0]   cnt_q,         cnt_d;
    logic [LAT_W-1:0]   lat_q,         lat_d;
    logic [1:0]         ctrl_q,        ctrl_d;
    logic [CNT_W-1:0]   period_q,      period_d;
    logic [WIDTH-1:0]   edge_q,        edge_d;
    logic [WIDTH-1:0]   flags_q,       flags_d;
    logic               flags_valid_q, flags_valid_d;
    logic [WIDTH-1:0]   sample_q,      sample_d;
    logic [WIDTH-1:0]   prev_q,        prev_d;
    logic               has_prev_q,    has_prev_d;
    logic [STB_W-1:0]   stable_q,      stable_d;
    logic               m_read_q,      m_read_d;
    logic [31:0]        s_readdata_q,  s_readdata_d;

    logic [CNT_W-1:0]   reload;
    logic [WIDTH-1:0]   edge_set;
    logic [WIDTH-1:0]   edge_w1c;
    logic [STB_W-1:0]   stable_new;
    logic [31:0]        rd_mux;
    logic               unused_bits;

    assign unused_bits = ^{m_readdata[31:WIDTH], s_writedata[31:CNT_W]};

    // A programmed period of 0 is treated as 1.
    assign reload = ((period_q == '0) ? CNT_W'(1) : period_q) - CNT_W'(1);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        lat_d         = lat_q;
        ctrl_d        = ctrl_q;
        period_d      = period_q;
        flags_d       = flags_q;
        flags_valid_d = flags_valid_q;
        sample_d      = sample_q;
        prev_d        = prev_q;
        has_prev_d    = has_prev_q;
        stable_d      = stable_q;
        m_read_d      = 1'b0;
        edge_set      = '0;
        edge_w1c      = '0;
        stable_new    = stable_q;
        rd_mux        = '0;

        if (s_write) begin
            case (s_address)
                2'd0:    ctrl_d   = s_writedata[1:0];
                2'd1:    period_d = s_writedata[CNT_W-1:0];
                2'd3:    edge_w1c = s_writedata[WIDTH-1:0];
                default: ;
            endcase
        end

        // Disabling aborts any poll in flight and restarts debounce history.
        if (!ctrl_q[0]) begin
            state_d    = IDLE;
            stable_d   = '0;
            has_prev_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = WAIT;
                    cnt_d   = reload;
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_d  = READ;
                        m_read_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                READ: begin
                    state_d = LAT;
                    lat_d   = LAT_W'(READ_LATENCY - 1);
                end
                LAT: begin
                    if (lat_q == '0) begin
                        sample_d = m_readdata[WIDTH-1:0];
                        state_d  = EVAL;
                    end else begin
                        lat_d = lat_q - LAT_W'(1);
                    end
                end
                EVAL: begin
                    if (!has_prev_q || (sample_q != prev_q)) begin
                        stable_new = STB_W'(1);
                    end else if (stable_q == STB_MAX) begin
                        stable_new = STB_MAX;
                    end else begin
                        stable_new = stable_q + STB_W'(1);
                    end
                    stable_d   = stable_new;
                    prev_d     = sample_q;
                    has_prev_d = 1'b1;
                    if ((stable_new == STB_MAX) && ((sample_q != flags_q) || !flags_valid_q)) begin
                        flags_d       = sample_q;
                        flags_valid_d = 1'b1;
                        if (flags_valid_q) begin
                            edge_set = sample_q ^ flags_q;
                        end
                    end
                    state_d = WAIT;
                    cnt_d   = reload;
                end
                default: state_d = IDLE;
            endcase
        end

        // A new change beats a simultaneous write-1-to-clear on the same bit.
        edge_d = (edge_q & ~edge_w1c) | edge_set;

        case (s_address)
            2'd0: rd_mux = {30'b0, ctrl_q};
            2'd1: rd_mux = 32'(period_q);
            2'd2: begin
                rd_mux     = 32'(flags_q);
                rd_mux[31] = flags_valid_q;
            end
            default: rd_mux = 32'(edge_q);
        endcase
        s_readdata_d = s_read ? rd_mux : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            lat_q         <= '0;
            ctrl_q        <= '0;
            period_q      <= CNT_W'(PERIOD_DEFAULT);
            edge_q        <= '0;
            flags_q       <= '0;
            flags_valid_q <= 1'b0;
            sample_q      <= '0;
            prev_q        <= '0;
            has_prev_q    <= 1'b0;
            stable_q      <= '0;
            m_read_q      <= 1'b0;
            s_readdata_q  <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            lat_q         <= lat_d;
            ctrl_q        <= ctrl_d;
            period_q      <= period_d;
            edge_q        <= edge_d;
            flags_q       <= flags_d;
            flags_valid_q <= flags_valid_d;
            sample_q      <= sample_d;
            prev_q        <= prev_d;
            has_prev_q    <= has_prev_d;
            stable_q      <= stable_d;
            m_read_q      <= m_read_d;
            s_readdata_q  <= s_readdata_d;
        end
    end

    assign m_address   = 2'b00;
    assign m_read      = m_read_q;
    assign s_readdata  = s_readdata_q;
    assign flags       = flags_q;
    assign flags_valid = flags_valid_q;
    assign irq         = ctrl_q[1] & (|edge_q);

endmodule
